// File: rtl/gpu_pkg.sv
// Shared GPU-slice definitions: memory map, matrix geometry and the result-drain state encoding.
package gpu_pkg;

    localparam int RESULT_BASE_ADDR = 6144;
    localparam int A_BASE_ADDR      = 2048;
    localparam int B_BASE_ADDR      = 4096;

    localparam int MAT_DIM    = 16;
    localparam int MAT_WORDS  = 256;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CORES,
        READ,
        FLUSH,
        DONE
    } drain_state_t;

endpackage

// File: rtl/drain_fifo.sv
// Synchronous show-ahead FIFO for drain entries; head is valid whenever empty is low.
module drain_fifo #(
    parameter int W     = 41,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop frees its slot in the same cycle, so a push into a full FIFO is accepted alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/gpu_result_drain.sv
// Completion-driven drain of the 16x16 result matrix from RAM to a valid/ready stream.
// Build option DRAIN_CHECKSUM_EN adds a running sum of every accepted output word.
module gpu_result_drain
    import gpu_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int NUM_WORDS   = MAT_WORDS,
    parameter int RESULT_BASE = RESULT_BASE_ADDR,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int IDLE_STABLE = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] core_idle,
    output logic                 ram_rd_en,
    output logic [ADDR_W-1:0]    ram_addr,
    input  logic [DATA_W-1:0]    ram_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [7:0]           out_index,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    checksum
);
    localparam int IW    = 9;
    localparam int IC_W  = $clog2(IDLE_STABLE + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = 1 + 8 + DATA_W;

    drain_state_t      state, state_nx;
    logic [IC_W-1:0]   idle_cnt, idle_cnt_nx;
    logic [IW-1:0]     rd_ptr;
    logic [IW-1:0]     cap_idx;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] issue_addr;
    logic              inflight;
    logic              issue;
    logic              launch;
    logic              room;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  push_ent;
    logic [ENT_W-1:0]  head_ent;

    assign issue_addr = ADDR_W'(RESULT_BASE) + ADDR_W'({rd_ptr, 2'b00});
    assign room       = !fifo_full && ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);

    always_comb begin
        state_nx    = state;
        idle_cnt_nx = idle_cnt;
        issue       = 1'b0;
        launch      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    launch      = 1'b1;
                    idle_cnt_nx = '0;
                    state_nx    = WAIT_CORES;
                end
            end
            WAIT_CORES: begin
                if (&core_idle) begin
                    idle_cnt_nx = idle_cnt + IC_W'(1);
                    if (idle_cnt == IC_W'(IDLE_STABLE - 1)) state_nx = READ;
                end else begin
                    idle_cnt_nx = '0;
                end
            end
            READ: begin
                if (room) begin
                    issue = 1'b1;
                    if (rd_ptr == IW'(NUM_WORDS - 1)) state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (!inflight && fifo_empty) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            idle_cnt <= '0;
            rd_ptr   <= '0;
            cap_idx  <= '0;
            addr_q   <= ADDR_W'(RESULT_BASE);
            inflight <= 1'b0;
        end else begin
            state    <= state_nx;
            idle_cnt <= idle_cnt_nx;
            inflight <= issue;
            if (launch) rd_ptr <= '0;
            if (issue) begin
                rd_ptr  <= rd_ptr + IW'(1);
                cap_idx <= rd_ptr;
                addr_q  <= issue_addr;
            end
        end
    end

    assign ram_rd_en = issue;
    assign ram_addr  = issue ? issue_addr : addr_q;

    // RAM data returns one cycle after the strobe and is tagged with the index captured at issue.
    assign push_ent = {(cap_idx == IW'(NUM_WORDS - 1)), cap_idx[7:0], ram_rdata};

    drain_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (inflight),
        .push_data (push_ent),
        .pop       (pop),
        .head      (head_ent),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Handshake: a word transfers on a rising CLK when out_valid and out_ready are both high;
    // out_valid never depends on out_ready and the head stays put until that transfer.
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    always_comb begin
        {out_last, out_index, out_data} = '0;
        if (!fifo_empty) {out_last, out_index, out_data} = head_ent;
    end

    assign busy = (state == WAIT_CORES) || (state == READ) || (state == FLUSH);
    assign done = (state == DONE);

`ifdef DRAIN_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge CLK) begin
        if (RESET || launch) sum_q <= '0;
        else if (pop)        sum_q <= sum_q + out_data;
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_gpu_result_drain.sv
// Directed bench for gpu_result_drain: RAM model, per-word scoreboard, latency and backpressure checks.
module tb_gpu_result_drain;
    localparam int NUM_WORDS   = 256;
    localparam int IDLE_STABLE = 4;
    localparam int FIFO_DEPTH  = 4;
    localparam int BASE        = 6144;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [3:0]  core_idle;
    logic        ram_rd_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_rdata = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ram_mem [NUM_WORDS];
    logic [31:0] ram_off;
    logic [31:0] exp_q [$];

    always #5 CLK = ~CLK;

    gpu_result_drain dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .core_idle (core_idle),
        .ram_rd_en (ram_rd_en),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    assign ram_off = (ram_addr - 32'(BASE)) >> 2;

    always @(posedge CLK) begin
        if (ram_rd_en) ram_rdata <= ram_mem[ram_off[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},  32'(ram_rd_en), 0);
        check({tag, "_addr"},   ram_addr, BASE);
        check({tag, "_valid"},  32'(out_valid), 0);
        check({tag, "_data"},   out_data, 0);
        check({tag, "_index"},  32'(out_index), 0);
        check({tag, "_last"},   32'(out_last), 0);
        check({tag, "_busy"},   32'(busy), 0);
        check({tag, "_done"},   32'(done), 0);
        check({tag, "_chksum"}, checksum, 0);
    endtask

    function automatic logic [3:0] idle_pat(input int c);
        if (c < 50)      return 4'b0111;
        else if (c < 52) return 4'b1111;
        else if (c < 55) return 4'b0111;
        else             return 4'b1111;
    endfunction

    // mode 0: always ready, 1: 20-cycle stall at word 100, 2: ready toggles, 3: RESET at word 100
    task automatic run_drain(input int mode, input bit gated, input int exp_first);
        int acc, reads, first_rd, last_rd, stall_left, max_out;
        bit stalled, held_v;
        logic [31:0] held, w, exp_sum;
        exp_q.delete();
        exp_sum = 0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            exp_q.push_back(ram_mem[i]);
            exp_sum += ram_mem[i];
        end
        acc = 0; reads = 0; first_rd = -1; last_rd = -1;
        stall_left = 0; max_out = 0; stalled = 0; held_v = 0; held = '0;
        for (int cyc = 0; cyc < 3000 && !(acc == NUM_WORDS && done); cyc++) begin
            @(negedge CLK);
            start     = (cyc == 0);
            core_idle = gated ? idle_pat(cyc) : 4'b1111;
            if (mode == 3 && acc == 100) begin
                RESET = 1'b1;
                @(negedge CLK);
                RESET = 1'b0;
                #1;
                check_reset_outputs("mid_reset");
                return;
            end
            if (mode == 1 && acc == 100 && !stalled) begin
                stall_left = 20;
                stalled    = 1;
            end
            if (mode == 2) out_ready = (cyc % 2) == 1;
            else           out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            #1;
            if (ram_rd_en) begin
                if (first_rd < 0) begin
                    first_rd = cyc;
                    check("first_rd_addr", ram_addr, BASE);
                end
                last_rd = cyc;
                reads++;
                if (reads - acc > max_out) max_out = reads - acc;
            end
            if (held_v) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("word_data", out_data, w);
                    check("word_index", 32'(out_index), 32'(acc % 256));
                    check("word_last", 32'(out_last), 32'(acc == NUM_WORDS - 1));
                end
                acc++;
                held_v = 0;
            end else if (out_valid) begin
                held_v = 1;
                held   = out_data;
            end else begin
                held_v = 0;
            end
        end
        check("first_rd_cycle", first_rd, exp_first);
        check("words_accepted", acc, NUM_WORDS);
        check("queue_empty", exp_q.size(), 0);
        check("done_level", 32'(done), 1);
        check("busy_at_done", 32'(busy), 0);
        check("outstanding_le_depth", 32'(max_out <= FIFO_DEPTH), 1);
        if (mode == 0) check("rd_sustained", last_rd - first_rd, NUM_WORDS - 1);
        if (mode == 1) check("stall_fill", max_out, FIFO_DEPTH);
`ifdef DRAIN_CHECKSUM_EN
        check("checksum", checksum, exp_sum);
`else
        check("checksum", checksum, 0);
`endif
    endtask

    initial begin
        RESET     = 1'b1;
        start     = 1'b0;
        core_idle = 4'b0000;
        out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check_reset_outputs("reset");
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < NUM_WORDS; i++) ram_mem[i] = 32'(i * 3);
        run_drain(0, 0, 1 + IDLE_STABLE);
        run_drain(0, 1, 59);
        run_drain(1, 0, 1 + IDLE_STABLE);
        run_drain(2, 0, 1 + IDLE_STABLE);
        run_drain(3, 0, 1 + IDLE_STABLE);
        run_drain(0, 0, 1 + IDLE_STABLE);

        for (int i = 0; i < NUM_WORDS; i++) ram_mem[i] = 32'hFFFF_FFFF;
        run_drain(0, 0, 1 + IDLE_STABLE);
        @(negedge CLK);
        #1;
`ifdef DRAIN_CHECKSUM_EN
        check("checksum_all_ones", checksum, 32'hFFFF_FF00);
`else
        check("checksum_all_ones", checksum, 0);
`endif
        check("done_hold", 32'(done), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gpu_result_drain.md
Name: gpu_result_drain

Overview:
Downstream stage of the GPU top. Once the four MinimalistCPU cores finish, it reads the 16x16 int32 result region out of the unified multiport RAM through one read port. It then streams the words, in order, over a valid/ready interface to the host/testbench side. This replaces the fixed-cycle result readback with a handshaked, completion-driven drain.

Parameters:
NUM_CORES, 4, number of cores whose IDLE flags gate the drain
NUM_WORDS, 256, result words to drain (16x16 matrix)
RESULT_BASE, 6144, byte address of result word 0 in RAM
DATA_W, 32, data word width
ADDR_W, 32, RAM address width
FIFO_DEPTH, 4, output buffer depth in words (power of 2, >=2)
IDLE_STABLE, 4, consecutive cycles all cores must report IDLE before reading starts

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; arms the drain after cores are launched
core_idle  in  NUM_CORES  IDLE flags from cores u0..u3
ram_rd_en  out  1  read strobe to the RAM port
ram_addr  out  ADDR_W  byte address to the RAM port
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_rd_en
out_valid  out  1  output word available
out_ready  in  1  consumer accepts the word when high with out_valid
out_data  out  DATA_W  result word
out_index  out  8  word index 0..NUM_WORDS-1 (row*16+col)
out_last  out  1  high with the final word (index NUM_WORDS-1)
busy  out  1  high in states other than IDLE/DONE
done  out  1  level; high in DONE
checksum  out  DATA_W  see Optional Feature

Behaviour:
- Reset: state=IDLE; ram_rd_en=0, ram_addr=RESULT_BASE, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, checksum=0; FIFO emptied; counters cleared.
- States: IDLE -> WAIT_CORES -> READ -> FLUSH -> DONE.
- IDLE: start=1 -> WAIT_CORES, clear idle_cnt.
- WAIT_CORES:
  - idle_cnt increments while &core_idle is 1 and clears whenever it is 0.
  - When idle_cnt reaches IDLE_STABLE-1 with &core_idle=1, go to READ (IDLE_STABLE cycles total).
- READ:
  - Issue a read at rd_ptr when (fifo_count + inflight) < FIFO_DEPTH.
  - ram_addr = RESULT_BASE + 4*rd_ptr; ram_rd_en=1 for that cycle only; inflight set.
  - ram_rdata is captured into the FIFO the following cycle.
  - Back-to-back reads are allowed: one word per cycle while out_ready holds high.
  - After issuing word NUM_WORDS-1 -> FLUSH.
- FLUSH: no new reads; wait for the last capture and for the FIFO to empty -> DONE.
- DONE: done=1. start -> WAIT_CORES with all counters cleared, done=0.
- start is ignored in WAIT_CORES, READ and FLUSH.
- Output: FIFO head drives out_data/out_index/out_last. It is show-ahead, so out_valid=1 means the FIFO is non-empty.
- Once out_valid rises, out_data/index/last stay stable until accepted (out_valid&out_ready).
- Simultaneous FIFO push and pop is allowed, including when the FIFO is full, because a pop frees a slot for the same-cycle push.
- Backpressure: with out_ready held low, at most FIFO_DEPTH reads are outstanding plus buffered; no RAM data is dropped.
- ram_addr holds its last value when ram_rd_en=0.
- Widths: rd_ptr and out_index are 9-bit internally so they can reach 256; output index is the low 8 bits.
- RESET mid-operation: aborts immediately to the reset state; an in-flight RAM read is discarded.

Optional Feature:
DRAIN_CHECKSUM_EN
- Defined: checksum is a wrapping 32-bit sum of every accepted out_data word. It is cleared on start and is final and stable while done=1.
- Undefined: no accumulator logic; checksum is tied to 0.

Decomposition:
- Shared package gpu_pkg holds:
  - RESULT_BASE_ADDR=6144, A_BASE_ADDR=2048, B_BASE_ADDR=4096
  - MAT_DIM=16, MAT_WORDS=256, WORD_BYTES=4
  - drain state enum (IDLE, WAIT_CORES, READ, FLUSH, DONE)
- One sub-module: drain_fifo, a synchronous show-ahead FIFO carrying {last, index, data} with full/empty/count.

Test Plan:
- Reset values: after RESET, check all outputs at reset values. Then start with core_idle=4'b1111 -> first ram_rd_en at cycle 1+IDLE_STABLE after start, ram_addr=6144.
- Full drain, out_ready=1, RAM[6144+4i]=i*3 -> 256 words, out_data=i*3, out_index=i, out_last only at i=255, then done=1; RAM reads sustained one per cycle.
- Gated start: core_idle=4'b0111 for 50 cycles, then a glitch 1111 for 2 cycles, then steady 1111 -> no read until the steady window reaches IDLE_STABLE.
- Backpressure: out_ready low for 20 cycles mid-stream -> at most 4 words buffered, out_data stable while stalled, no word lost or duplicated. Also toggle out_ready every cycle and check the ordered sequence 0..255.
- RESET asserted at word 100 -> outputs return to reset values next cycle; a new start drains from index 0.
- DRAIN_CHECKSUM_EN: RAM[i]=0xFFFFFFFF for all words -> checksum=0xFFFFFF00 at done. Without the macro -> checksum=0.
